// File: rtl/student_circuit_pkg.sv
// Shared types and constants for the selective-inversion decoder.
// Holds frame geometry, the control state enum and the phase index type.
// No logic lives here.
package student_circuit_pkg;

    localparam int PHASES    = 8;
    localparam int INV_START = 5;
    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 32;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef logic [2:0] phase_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word buffer between the byte packer and the consumer.
// Latency: a pushed word is visible at the head on the edge after the push.
// Backpressure: a push while full with no pop is ignored; a push and pop on the same edge both take effect.
module word_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_q;
    logic         wr_q;
    logic [1:0]   cnt_q;
    logic         wr_en;
    logic         rd_en;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_q];

    // A full buffer still takes a word when the head leaves on the same edge.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= ~wr_q;
            end
            if (rd_en) begin
                rd_q <= ~rd_q;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/student_circuit_decode.sv
// Undoes the encoder's phase-dependent inversion, packs bytes into 32-bit words and sums each frame.
// Latency: a word reaches out_word one edge after the encoder registers its last byte.
// Backpressure: none upstream; a word arriving at a full buffer is dropped and sets sticky overflow.
module student_circuit_decode #(
    parameter int PHASES    = 8,
    parameter int INV_START = 5
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [7:0]  enc_in,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  frame_sum,
    output logic        frame_done,
    output logic        overflow
);

    import student_circuit_pkg::*;

    localparam phase_t LAST_PHASE = phase_t'(PHASES - 1);
    localparam phase_t FIRST_INV  = phase_t'(INV_START);

    state_e              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [BYTE_W-1:0]   acc_q, acc_d;
    logic [BYTE_W-1:0]   frame_sum_q, frame_sum_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic [BYTE_W-1:0]   restored;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;

    // Late phases arrive inverted; flip them back.
    assign restored = (phase_q >= FIRST_INV) ? ~enc_in : enc_in;

    assign pop        = out_valid && out_ready;
    assign out_valid  = !fifo_empty;
    assign frame_sum  = frame_sum_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    // Phase tracking, byte packing, frame accumulation and overflow detection.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        asm_d        = asm_q;
        acc_d        = acc_q;
        frame_sum_d  = frame_sum_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        push         = 1'b0;
        case (state_q)
            // The encoder output is still its cleared value on this edge.
            PRIME: state_d = RUN;
            RUN: begin
                phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + phase_t'(1);
                asm_d[{phase_q[1:0], 3'b000} +: BYTE_W] = restored;
                acc_d = (phase_q == '0) ? restored : acc_q + restored;
                if (phase_q == LAST_PHASE) begin
                    frame_sum_d  = acc_q + restored;
                    frame_done_d = 1'b1;
                end
                // Last byte of a word: push the merged word on this same edge.
                if (phase_q[1:0] == 2'd3) begin
                    push = 1'b1;
                    if (fifo_full && !pop) begin
                        overflow_d = 1'b1;
                    end
                end
            end
            default: state_d = PRIME;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= PRIME;
            phase_q      <= '0;
            asm_q        <= '0;
            acc_q        <= '0;
            frame_sum_q  <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            asm_q        <= asm_d;
            acc_q        <= acc_d;
            frame_sum_q  <= frame_sum_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    word_fifo2 #(
        .W (WORD_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (clear),
        .push_i     (push),
        .push_dat_i (asm_d),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (out_word)
    );

endmodule

// File: doc/student_circuit_decode.md
# student_circuit_decode

Downstream stage of the 8-phase selective-inversion encoder. It samples the encoder's registered 8-bit output and tracks the encoder's phase from the shared clear. It re-inverts phases 5–7 to recover the original bytes, packs them into 32-bit words behind a 2-entry buffer with a valid/ready handshake, and reports a per-frame modulo-256 byte sum. The upstream stage cannot stall, so a full buffer drops words and raises a sticky overflow flag.

## Interface
Parameters:
- PHASES, 8, bytes per frame; the encoder's counter period.
- INV_START, 5, first inverted phase; phases INV_START..PHASES-1 arrive inverted.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- clear, input, 1, asynchronous, active-high reset; the same net that clears the encoder.
- enc_in, input, 8, encoder registered output.
- out_word, output, 32, head-of-buffer word; byte of phase 0 (or 4) in bits [7:0].
- out_valid, output, 1, buffer non-empty.
- out_ready, input, 1, consumer accepts out_word this cycle.
- frame_sum, output, 8, modulo-256 sum of the 8 restored bytes of the last completed frame.
- frame_done, output, 1, one-cycle pulse when frame_sum updates.
- overflow, output, 1, sticky; a completed word was dropped.

## Operation
- Reset values while clear is high: state PRIME, phase 0, assembly register 0, buffer empty, out_word 0, out_valid 0, frame_sum 0, frame_done 0, overflow 0.
- States:
  - PRIME: the first edge after clear deasserts discards enc_in, which still holds the encoder's cleared value 0. Transition to RUN.
  - RUN: every edge samples one byte at the current phase p (3-bit counter).
- Decode: restored byte = enc_in if p < INV_START, else ~enc_in.
- Phase advances each RUN edge, wrapping 7 to 0. There is no resync path other than clear.
- Packing:
  - Phases 0–3 form word A; phases 4–7 form word B.
  - Byte of phase p goes to bits [8*(p mod 4)+7 : 8*(p mod 4)].
  - The word is complete on the edge that samples phase 3 or phase 7. The completing byte is merged combinationally and the word is pushed on that same edge.
- Buffer: 2-entry FIFO.
  - Pop when out_valid && out_ready.
  - Push with buffer full and no pop: word discarded, overflow set to 1 until clear.
  - Push with buffer full and a pop on the same edge: accepted, count unchanged.
  - Push and pop with 1 entry: accepted, count stays 1, head becomes the pushed word.
  - Order strictly FIFO.
- Frame sum:
  - 8-bit accumulator, cleared to 0 at phase 0 (loads that byte).
  - On the phase-7 edge, frame_sum is loaded with accumulator + byte (mod 256) and frame_done pulses.
- clear asserted mid-frame: everything returns to reset values immediately. The partial word and partial sum are lost. After release, the block re-enters PRIME.

## Timing
- Edge numbering: e0 is the first edge with clear low. The encoder produces phase k at e_k; this block discards at e0 and samples phase k at e_{k+1}.
- Word A pushed at e4; out_valid high after e4 (1-cycle latency from the encoder's phase-3 register).
- Word B pushed at e8.
- frame_sum valid and frame_done high after e8. Subsequent frames: every 8 cycles (e16, e24, ...).
- out_word is driven directly from the buffer head. It is stable while out_valid && !out_ready.
- No combinational path from out_ready to out_valid.

## Structure
- Package student_circuit_pkg holds:
  - PHASES, INV_START, BYTE_W = 8, WORD_W = 32.
  - State enum {PRIME, RUN}.
  - A phase-index typedef (3 bits).
- Sub-module word_fifo2 (2-entry, WORD_W wide, push/pop/full/empty) holds the buffer. The rest is decode, phase counter, assembly register and accumulator in the top.

## Test plan
- Constant 8'h3C into encoder, out_ready = 1:
  - words 32'h3C3C3C3C at e4 and e8, repeating;
  - frame_sum 8'hE0 with frame_done at e8;
  - overflow stays 0.
- Encoder input ramp 8'h00..8'h07 per frame:
  - word A 32'h03020100, word B 32'h07060504;
  - frame_sum 8'h1C.
- out_ready held 0 with constant input 8'hFF:
  - buffer holds words from e4 and e8;
  - word at e12 is dropped and overflow = 1;
  - raising out_ready drains both stored words in order; overflow stays 1.
- Simultaneous push and pop with buffer full (out_ready asserted on e12):
  - no drop, overflow 0;
  - next out_word is the e8 word.
- clear pulsed at e6 (mid word B):
  - after release, no word B from the old frame;
  - first word is the new-frame word A at new e4;
  - frame_done does not pulse before new e8.
